// File: rtl/gpgpu_multicore_controller.sv
// Multicore run controller: per-core clock-gate/reset sequencing, run-cycle
// counters and a maskable done interrupt behind a zero-wait OBI register slave.
module gpgpu_multicore_controller #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 regs_req_i,
  input  logic                 regs_we_i,
  input  logic [31:0]          regs_addr_i,
  input  logic [31:0]          regs_wdata_i,
  output logic                 regs_gnt_o,
  output logic                 regs_rvalid_o,
  output logic [31:0]          regs_rdata_o,
  input  logic [NUM_CORES-1:0] core_busy_i,
  output logic [NUM_CORES-1:0] clk_en_core_o,
  output logic [NUM_CORES-1:0] rst_n_core_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } coreState_e;

  localparam logic [5:0] OFF_START  = 6'h00;
  localparam logic [5:0] OFF_DONE   = 6'h01;
  localparam logic [5:0] OFF_IRQ_EN = 6'h02;
  localparam logic [5:0] OFF_ABORT  = 6'h03;
  localparam int         CYC_BASE   = 4;
  localparam logic [7:0] RST_LOAD   = 8'(RST_CYCLES - 1);

  logic [5:0]                 wordAddr;
  logic                       wrEn;
  logic                       rdEn;
  logic [NUM_CORES-1:0]       startHit;
  logic [NUM_CORES-1:0]       abortHit;
  logic [NUM_CORES-1:0]       doneClr;
  logic [NUM_CORES-1:0]       doneSet;
  logic [NUM_CORES-1:0]       running;
  logic [NUM_CORES-1:0][31:0] cyclesVec;
  logic [NUM_CORES-1:0]       done_q, done_d;
  logic [NUM_CORES-1:0]       irqEn_q, irqEn_d;
  logic                       irq_q;
  logic                       rvalid_q;
  logic [31:0]                rdata_q, rdata_d;
  logic                       unusedBits;

  assign wordAddr   = regs_addr_i[7:2];
  assign wrEn       = regs_req_i & regs_we_i;
  assign rdEn       = regs_req_i & ~regs_we_i;
  assign regs_gnt_o = regs_req_i;
  assign unusedBits = ^{regs_addr_i[31:8], regs_addr_i[1:0], regs_wdata_i[31:NUM_CORES]};

  assign startHit = (wrEn && wordAddr == OFF_START) ? regs_wdata_i[NUM_CORES-1:0] : '0;
  assign abortHit = (wrEn && wordAddr == OFF_ABORT) ? regs_wdata_i[NUM_CORES-1:0] : '0;
  assign doneClr  = (wrEn && wordAddr == OFF_DONE)  ? regs_wdata_i[NUM_CORES-1:0] : '0;

  for (genvar i = 0; i < NUM_CORES; i++) begin : genCore
    coreState_e  state_q, state_d;
    logic [7:0]  rstCnt_q, rstCnt_d;
    logic        busySeen_q, busySeen_d;
    logic [31:0] cycles_q, cycles_d;
    logic        doneSetCore;

    // Counting depends only on being in RUN, so an aborting RUN cycle still counts.
    always_comb begin
      state_d     = state_q;
      rstCnt_d    = rstCnt_q;
      busySeen_d  = busySeen_q;
      cycles_d    = cycles_q;
      doneSetCore = 1'b0;
      case (state_q)
        IDLE: begin
          if (startHit[i]) begin
            state_d  = RESET;
            rstCnt_d = RST_LOAD;
            cycles_d = '0;
          end
        end
        RESET: begin
          if (rstCnt_q == 8'd0) begin
            state_d    = RUN;
            busySeen_d = 1'b0;
          end else begin
            rstCnt_d = rstCnt_q - 8'd1;
          end
        end
        RUN: begin
          if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
          if (core_busy_i[i]) busySeen_d = 1'b1;
          if (busySeen_q && !core_busy_i[i]) begin
            state_d     = DONE;
            doneSetCore = 1'b1;
          end
        end
        DONE: begin
          if (doneClr[i]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (abortHit[i]) begin
        state_d     = IDLE;
        doneSetCore = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q    <= IDLE;
        rstCnt_q   <= '0;
        busySeen_q <= 1'b0;
        cycles_q   <= '0;
      end else begin
        state_q    <= state_d;
        rstCnt_q   <= rstCnt_d;
        busySeen_q <= busySeen_d;
        cycles_q   <= cycles_d;
      end
    end

    assign doneSet[i]       = doneSetCore;
    assign running[i]       = (state_q == RESET) || (state_q == RUN);
    assign clk_en_core_o[i] = (state_q == RESET) || (state_q == RUN);
    assign rst_n_core_o[i]  = (state_q == RUN) || (state_q == DONE);
    assign cyclesVec[i]     = cycles_q;
  end

  // A done event overrides a simultaneous W1C of the same bit.
  always_comb begin
    done_d  = (done_q & ~doneClr) | doneSet;
    irqEn_d = irqEn_q;
    if (wrEn && wordAddr == OFF_IRQ_EN) irqEn_d = regs_wdata_i[NUM_CORES-1:0];
    rdata_d = '0;
    if (rdEn) begin
      case (wordAddr)
        OFF_START:  rdata_d = 32'(running);
        OFF_DONE:   rdata_d = 32'(done_q);
        OFF_IRQ_EN: rdata_d = 32'(irqEn_q);
        default: begin
          for (int k = 0; k < NUM_CORES; k++) begin
            if (wordAddr == 6'(CYC_BASE + k)) rdata_d = cyclesVec[k];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_q   <= '0;
      irqEn_q  <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      done_q   <= done_d;
      irqEn_q  <= irqEn_d;
      irq_q    <= |(done_q & irqEn_q);
      rvalid_q <= regs_req_i;
      rdata_q  <= rdata_d;
    end
  end

  assign regs_rvalid_o = rvalid_q;
  assign regs_rdata_o  = rdata_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_gpgpu_multicore_controller.sv
// Directed bench for gpgpu_multicore_controller with a cycle-level reference
// model of the per-core sequencing, checked against the DUT every cycle.
module tb_gpgpu_multicore_controller;

  localparam int NUM_CORES  = 4;
  localparam int RST_CYCLES = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_RESET = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DONE  = 3;

  logic                 clk = 1'b0;
  logic                 rstN = 1'b0;
  logic                 regsReq = 1'b0;
  logic                 regsWe = 1'b0;
  logic [31:0]          regsAddr = '0;
  logic [31:0]          regsWdata = '0;
  logic                 regsGnt;
  logic                 regsRvalid;
  logic [31:0]          regsRdata;
  logic [NUM_CORES-1:0] busyVec = '0;
  logic [NUM_CORES-1:0] clkEnCore;
  logic [NUM_CORES-1:0] rstNCore;
  logic                 irq;

  int testsRun = 0;
  int testsFailed = 0;
  int forceSeq = 0;

  gpgpu_multicore_controller #(
    .NUM_CORES (NUM_CORES),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .regs_req_i   (regsReq),
    .regs_we_i    (regsWe),
    .regs_addr_i  (regsAddr),
    .regs_wdata_i (regsWdata),
    .regs_gnt_o   (regsGnt),
    .regs_rvalid_o(regsRvalid),
    .regs_rdata_o (regsRdata),
    .core_busy_i  (busyVec),
    .clk_en_core_o(clkEnCore),
    .rst_n_core_o (rstNCore),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: phase, remaining reset cycles and run count per core
  int                   mPhase     [NUM_CORES];
  int                   mResetLeft [NUM_CORES];
  bit                   mBusySeen  [NUM_CORES];
  logic [31:0]          mCycles    [NUM_CORES];
  logic [NUM_CORES-1:0] mDone;
  logic [NUM_CORES-1:0] mIrqEn;
  logic                 mIrq;
  logic                 mRvalid;
  logic [31:0]          mRdata;
  bit                   modelValid = 1'b0;
  int                   forceSeen = 0;

  always @(posedge clk) begin
    int                   word;
    logic [31:0]          readVal;
    logic [NUM_CORES-1:0] startMask, abortMask, clrMask, setMask;
    if (!rstN) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        mPhase[k]     = PH_IDLE;
        mResetLeft[k] = 0;
        mBusySeen[k]  = 1'b0;
        mCycles[k]    = '0;
      end
      mDone      = '0;
      mIrqEn     = '0;
      mIrq       = 1'b0;
      mRvalid    = 1'b0;
      mRdata     = '0;
      modelValid = 1'b1;
      forceSeen  = forceSeq;
    end else begin
      // Core 3's counter was overwritten through the backdoor this cycle
      if (forceSeen != forceSeq) begin
        mCycles[3] = 32'hFFFF_FFFD;
        forceSeen  = forceSeq;
      end
      word    = {26'd0, regsAddr[7:2]};
      readVal = '0;
      if (regsReq && !regsWe) begin
        if (word == 0) begin
          for (int k = 0; k < NUM_CORES; k++)
            if (mPhase[k] == PH_RESET || mPhase[k] == PH_RUN) readVal[k] = 1'b1;
        end else if (word == 1) readVal = 32'(mDone);
        else if (word == 2) readVal = 32'(mIrqEn);
        else if (word >= 4 && word < 4 + NUM_CORES) readVal = mCycles[word-4];
      end
      mRvalid   = regsReq;
      mRdata    = readVal;
      mIrq      = |(mDone & mIrqEn);
      startMask = (regsReq && regsWe && word == 0) ? regsWdata[NUM_CORES-1:0] : '0;
      clrMask   = (regsReq && regsWe && word == 1) ? regsWdata[NUM_CORES-1:0] : '0;
      abortMask = (regsReq && regsWe && word == 3) ? regsWdata[NUM_CORES-1:0] : '0;
      setMask   = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        if (mPhase[k] == PH_RUN && mCycles[k] != 32'hFFFF_FFFF) mCycles[k] = mCycles[k] + 32'd1;
        if (mPhase[k] == PH_IDLE) begin
          if (startMask[k]) begin
            mPhase[k]     = PH_RESET;
            mResetLeft[k] = RST_CYCLES;
            mCycles[k]    = '0;
          end
        end else if (mPhase[k] == PH_RESET) begin
          mResetLeft[k] = mResetLeft[k] - 1;
          if (mResetLeft[k] == 0) begin
            mPhase[k]    = PH_RUN;
            mBusySeen[k] = 1'b0;
          end
        end else if (mPhase[k] == PH_RUN) begin
          if (mBusySeen[k] && !busyVec[k]) begin
            mPhase[k]  = PH_DONE;
            setMask[k] = 1'b1;
          end
          if (busyVec[k]) mBusySeen[k] = 1'b1;
        end else if (clrMask[k]) begin
          mPhase[k] = PH_IDLE;
        end
        if (abortMask[k]) begin
          mPhase[k]  = PH_IDLE;
          setMask[k] = 1'b0;
        end
      end
      mDone = (mDone & ~clrMask) | setMask;
      if (regsReq && regsWe && word == 2) mIrqEn = regsWdata[NUM_CORES-1:0];
    end
  end

  // Compare every cycle once the model has seen its first reset edge
  always @(negedge clk) begin
    logic [NUM_CORES-1:0] expEn, expRstN;
    if (modelValid) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        expEn[k]   = (mPhase[k] == PH_RESET) || (mPhase[k] == PH_RUN);
        expRstN[k] = (mPhase[k] == PH_RUN) || (mPhase[k] == PH_DONE);
      end
      checkOutput("model clk_en", 32'(clkEnCore), 32'(expEn));
      checkOutput("model rst_n", 32'(rstNCore), 32'(expRstN));
      checkOutput("model irq", 32'(irq), 32'(mIrq));
      checkOutput("model rvalid", 32'(regsRvalid), 32'(mRvalid));
      checkOutput("model gnt", 32'(regsGnt), 32'(regsReq));
      if (mRvalid) checkOutput("model rdata", regsRdata, mRdata);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    regsReq   = req;
    regsWe    = we;
    regsAddr  = addr;
    regsWdata = wdata;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic busRead(input string name, input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, addr, '0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput({name, " rvalid"}, 32'(regsRvalid), 32'd1);
    checkOutput(name, regsRdata, expected);
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) nextCycle();
    checkOutput("reset clk_en", 32'(clkEnCore), 32'd0);
    checkOutput("reset rst_n", 32'(rstNCore), 32'd0);
    checkOutput("reset irq", 32'(irq), 32'd0);
    checkOutput("reset rvalid", 32'(regsRvalid), 32'd0);
    rstN = 1'b1;
    busRead("START after reset", 32'h00, 32'h0);
    busRead("DONE after reset", 32'h04, 32'h0);

    // Core 0: four reset cycles with clock enabled, then run
    busWrite(32'h00, 32'h1);
    for (int c = 0; c < RST_CYCLES; c++) begin
      checkOutput("core0 reset clk_en", 32'(clkEnCore[0]), 32'd1);
      checkOutput("core0 reset rst_n", 32'(rstNCore[0]), 32'd0);
      nextCycle();
    end
    checkOutput("core0 run rst_n", 32'(rstNCore[0]), 32'd1);
    checkOutput("core0 run clk_en", 32'(clkEnCore[0]), 32'd1);

    // Three idle run cycles, ten busy, then the falling cycle: 14 counted cycles
    repeat (3) nextCycle();
    busyVec[0] = 1'b1;
    repeat (10) nextCycle();
    busyVec[0] = 1'b0;
    nextCycle();
    checkOutput("core0 done clk_en", 32'(clkEnCore[0]), 32'd0);
    checkOutput("core0 done rst_n", 32'(rstNCore[0]), 32'd1);
    checkOutput("irq masked", 32'(irq), 32'd0);
    busRead("DONE core0", 32'h04, 32'h1);
    busRead("CYCLES0", 32'h10, 32'd14);
    busWrite(32'h08, 32'h1);
    checkOutput("irq lags mask", 32'(irq), 32'd0);
    nextCycle();
    checkOutput("irq unmasked", 32'(irq), 32'd1);

    // W1C returns core 0 to idle; irq drops one cycle later
    busWrite(32'h04, 32'h1);
    checkOutput("core0 idle rst_n", 32'(rstNCore[0]), 32'd0);
    checkOutput("core0 idle clk_en", 32'(clkEnCore[0]), 32'd0);
    nextCycle();
    checkOutput("irq cleared", 32'(irq), 32'd0);

    // Core 1: a second START mid-reset must not extend the reset
    busWrite(32'h00, 32'h2);
    nextCycle();
    busWrite(32'h00, 32'h2);
    nextCycle();
    checkOutput("core1 still reset", 32'(rstNCore[1]), 32'd0);
    nextCycle();
    checkOutput("core1 run on time", 32'(rstNCore[1]), 32'd1);
    busRead("START running mask", 32'h00, 32'h2);
    busWrite(32'h0C, 32'h2);
    busRead("CYCLES1 kept on abort", 32'h14, 32'd2);
    busWrite(32'h00, 32'h2);
    busWrite(32'h0C, 32'h2);
    checkOutput("core1 abort clk_en", 32'(clkEnCore[1]), 32'd0);
    checkOutput("core1 abort rst_n", 32'(rstNCore[1]), 32'd0);
    busRead("DONE after abort", 32'h04, 32'h0);
    busRead("START after abort", 32'h00, 32'h0);

    // Core 2: done detection and W1C of the same bit in one cycle
    busWrite(32'h00, 32'h4);
    repeat (RST_CYCLES) nextCycle();
    busyVec[2] = 1'b1;
    nextCycle();
    busyVec[2] = 1'b0;
    busWrite(32'h04, 32'h4);
    busRead("DONE set wins", 32'h04, 32'h4);
    busRead("CYCLES2", 32'h18, 32'd2);
    busRead("unmapped 0x60", 32'h60, 32'h0);
    busWrite(32'h08, 32'hFFFF_FFFF);
    busRead("IRQ_EN upper bits", 32'h08, 32'hF);

    // Core 3: counter saturation, then reset while running
    busWrite(32'h00, 32'h8);
    repeat (RST_CYCLES + 2) nextCycle();
    force dut.genCore[3].cycles_q = 32'hFFFF_FFFD;
    forceSeq++;
    #1;
    release dut.genCore[3].cycles_q;
    repeat (4) nextCycle();
    busRead("CYCLES3 saturates", 32'h1C, 32'hFFFF_FFFF);
    checkOutput("core3 running rst_n", 32'(rstNCore[3]), 32'd1);
    checkOutput("irq from core2", 32'(irq), 32'd1);
    rstN = 1'b0;
    nextCycle();
    checkOutput("midrun reset clk_en", 32'(clkEnCore), 32'd0);
    checkOutput("midrun reset rst_n", 32'(rstNCore), 32'd0);
    checkOutput("midrun reset irq", 32'(irq), 32'd0);
    checkOutput("midrun reset rvalid", 32'(regsRvalid), 32'd0);
    rstN = 1'b1;
    busRead("CYCLES3 after reset", 32'h1C, 32'h0);
    busRead("DONE after reset 2", 32'h04, 32'h0);
    busRead("IRQ_EN after reset", 32'h08, 32'h0);
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
